mc_controller: RTL and testbench
================================

# mc_controller

Multicycle control unit for the ARM core. It sequences one shared datapath (single memory port, one ALU, instruction and data registers) through fetch, decode, execute and write-back. It sits beside `datapath` as the multicycle replacement for the single-cycle `controller`. It also owns the NZCV condition flags and stalls on a memory-ready handshake so slow memory can be used.

## Interface
- No parameters.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low reset.
- `Instr` in [31:12]: instruction register bits: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
- `ALUFlags` in 4: NZCV from datapath ALU, combinational, current cycle.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: load PC.
- `AdrSrc` out 1: 0 = memory address from PC, 1 = address from ALU result register.
- `IRWrite` out 1: load instruction register.
- `MemWrite` out 1: memory write strobe.
- `RegWrite` out 1: register file write.
- `ResultSrc` out 2: 00 ALUOut reg, 01 Data reg, 10 ALUResult direct.
- `ALUSrcA` out 1: 0 = register A, 1 = PC.
- `ALUSrcB` out 2: 00 register B, 01 ExtImm, 10 constant 4.
- `ALUControl` out 3: 000 ADD, 001 SUB, 010 AND, 011 ORR.
- `ImmSrc` out 2: equals Op.
- `RegSrc` out 2: [0] = (Op==10), [1] = (Op==01).

## Operation
- FSM states: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH
  - Outputs: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10.
  - IRWrite and PCWrite equal MemReady.
  - Stays in FETCH while MemReady=0; goes to DECODE when MemReady=1.
- DECODE
  - Outputs: ALUSrcA=1, ALUSrcB=10, ADD, ResultSrc=10 (produces PC+8).
  - If CondEx=0 → FETCH.
  - Else Op=01 → MEMADR; Op=00 with Funct[5]=0 → EXECR; Op=00 with Funct[5]=1 → EXECI; Op=10 → BRANCH; Op=11 → FETCH (no-op).
- MEMADR: ALUSrcA=0, ALUSrcB=01, ADD. Funct[0]=1 → MEMRD, else → MEMWR.
- MEMRD: AdrSrc=1. Waits for MemReady, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1 → FETCH.
- MEMWR: AdrSrc=1, MemWrite=1 held every cycle until MemReady=1, then → FETCH.
- EXECR
  - ALUSrcA=0, ALUSrcB=00; ALU operation decoded from Funct[4:1].
  - Cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP (uses SUB).
  - CMP → FETCH (no write-back); otherwise → ALUWB.
  - Other cmd values decode as ADD.
- EXECI: same as EXECR but ALUSrcB=01.
- ALUWB: ResultSrc=00, RegWrite=1 → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=1 → FETCH.
- Flags register (NZCV), updated at the clock edge ending EXECR/EXECI:
  - NZ are updated when Funct[0]=1.
  - CV are updated when Funct[0]=1 and cmd is ADD, SUB or CMP.
  - Flags are never written in any other state.
- CondEx from Cond and the stored flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - Cond=1111 gives CondEx=0.
- Destination Rd=15 is not supported for data-processing instructions; it is written as an ordinary register.

## Timing
- Reset (reset=0, asynchronous):
  - State becomes FETCH and flags become 0000.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 regardless of MemReady.
  - Deasserting reset mid-instruction abandons that instruction. Execution restarts at FETCH with no write strobe glitch.
- Output timing: all outputs are Moore from state, except FETCH IRWrite/PCWrite, which depend combinationally on MemReady.
- Cycles per instruction with MemReady always 1: LDR 5, STR 4, data-processing 4, CMP 3, B 3, failed condition 2.
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds exactly one cycle. Outputs hold constant during the wait.

## Structure
- Package `arm_ctrl_pkg` holds:
  - state enum;
  - ALUControl, ResultSrc and ALUSrcB code constants;
  - Op constants (DP=00, MEM=01, BR=10);
  - cmd constants.
- Sub-module `cond_check`: combinational, inputs Cond and flags, output CondEx.

## Test plan
- Reset, then MemReady=1 with Instr[31:12]=E0821 (ADD R1,R2,R3) → states FETCH, DECODE, EXECR, ALUWB. ALUControl=000 in EXECR; RegWrite=1 only in ALUWB; back in FETCH on the 5th cycle.
- E2521 (SUBS R1,R2,#5) with ALUFlags=0100 in EXECI → flags become 0100. A following 0A000 (BEQ) reaches BRANCH with PCWrite=1.
- E5921 (LDR) with MemReady low 3 cycles in MEMRD → 8 cycles total. AdrSrc=1 throughout MEMRD; RegWrite pulses once, in MEMWB.
- E5821 (STR) with MemReady low 2 cycles → MemWrite high exactly 3 cycles, then FETCH.
- E1510 (CMP) → no RegWrite, 3 cycles. 1A000 (BNE) with Z=1 → DECODE to FETCH, PCWrite only from FETCH.
- Assert reset during MEMWR with MemReady=0 → MemWrite drops immediately. After release, state is FETCH and flags are 0000.

Source files
------------

// File: rtl/mc_controller_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, datapath
// select codes, opcode/command values and the data-processing ALU decoder.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXECR  = 4'd6,
    S_EXECI  = 4'd7,
    S_ALUWB  = 4'd8,
    S_BRANCH = 4'd9
  } state_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // Unlisted commands fall back to ADD.
  function automatic logic [2:0] alu_decode(input logic [3:0] cmd);
    case (cmd)
      CMD_SUB, CMD_CMP: alu_decode = ALU_SUB;
      CMD_AND:          alu_decode = ALU_AND;
      CMD_ORR:          alu_decode = ALU_ORR;
      default:          alu_decode = ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Controller <-> datapath/memory bundle. state and flags are debug taps.
// MemReady handshake: an access issued by the controller (FETCH, MEMRD, MEMWR)
// completes in the cycle MemReady=1; while it is 0 the controller holds state and outputs.
interface mc_controller_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         MemReady;
  logic         PCWrite;
  logic         AdrSrc;
  logic         IRWrite;
  logic         MemWrite;
  logic         RegWrite;
  logic [1:0]   ResultSrc;
  logic         ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [2:0]   ALUControl;
  logic [1:0]   ImmSrc;
  logic [1:0]   RegSrc;
  logic [3:0]   state;
  logic [3:0]   flags;

  modport slave (
    input  Instr, ALUFlags, MemReady,
    output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, state, flags
  );

  modport master (
    output Instr, ALUFlags, MemReady,
    input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
           ALUSrcA, ALUSrcB, ALUControl, ImmSrc, RegSrc, state, flags
  );
endinterface

// File: rtl/mc_controller_cond_check.sv
// Evaluates an ARM condition field against the stored NZCV flags.
module cond_check (
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       condex
);
  logic n, z, c, v, ge;

  assign {n, z, c, v} = flags;
  assign ge = (n == v);

  always_comb begin
    condex = 1'b0;
    case (cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~(c & ~z);
      4'b1010: condex = ge;
      4'b1011: condex = ~ge;
      4'b1100: condex = ~z & ge;
      4'b1101: condex = ~(~z & ge);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control FSM: sequences fetch/decode/execute/write-back over a
// shared datapath, owns the NZCV flags and stalls on MemReady.
module mc_controller
  import arm_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.slave  bus
);
  state_e     state, next_state;
  logic [3:0] flags;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cmd;
  logic       condex;
  logic       pc_w, ir_w, mem_w, reg_w;

  assign cond  = bus.Instr[31:28];
  assign op    = bus.Instr[27:26];
  assign funct = bus.Instr[25:20];
  assign cmd   = funct[4:1];

  cond_check u_cond_check (
    .cond   (cond),
    .flags  (flags),
    .condex (condex)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_FETCH;
      flags <= 4'b0000;
    end else begin
      state <= next_state;
      // Flags latch on the edge leaving an execute state, only for S-suffixed ops.
      if ((state == S_EXECR || state == S_EXECI) && funct[0]) begin
        flags[3:2] <= bus.ALUFlags[3:2];
        if (cmd == CMD_ADD || cmd == CMD_SUB || cmd == CMD_CMP)
          flags[1:0] <= bus.ALUFlags[1:0];
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  next_state = bus.MemReady ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (!condex)              next_state = S_FETCH;
        else if (op == OP_MEM)    next_state = S_MEMADR;
        else if (op == OP_DP)     next_state = funct[5] ? S_EXECI : S_EXECR;
        else if (op == OP_BR)     next_state = S_BRANCH;
        else                      next_state = S_FETCH;
      end
      S_MEMADR: next_state = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  next_state = bus.MemReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  next_state = S_FETCH;
      S_MEMWR:  next_state = bus.MemReady ? S_FETCH : S_MEMWR;
      S_EXECR,
      S_EXECI:  next_state = (cmd == CMD_CMP) ? S_FETCH : S_ALUWB;
      S_ALUWB:  next_state = S_FETCH;
      S_BRANCH: next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  always_comb begin
    pc_w           = 1'b0;
    ir_w           = 1'b0;
    mem_w          = 1'b0;
    reg_w          = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.ALUSrcA    = 1'b0;
    bus.ALUSrcB    = SRCB_REG;
    bus.ALUControl = ALU_ADD;
    bus.ResultSrc  = RES_ALUOUT;
    case (state)
      S_FETCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
        ir_w          = bus.MemReady;
        pc_w          = bus.MemReady;
      end
      S_DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = SRCB_FOUR;
        bus.ResultSrc = RES_ALURESULT;
      end
      S_MEMADR: bus.ALUSrcB = SRCB_IMM;
      S_MEMRD:  bus.AdrSrc  = 1'b1;
      S_MEMWB: begin
        bus.ResultSrc = RES_DATA;
        reg_w         = 1'b1;
      end
      S_MEMWR: begin
        bus.AdrSrc = 1'b1;
        mem_w      = 1'b1;
      end
      S_EXECR: bus.ALUControl = alu_decode(cmd);
      S_EXECI: begin
        bus.ALUSrcB    = SRCB_IMM;
        bus.ALUControl = alu_decode(cmd);
      end
      S_ALUWB: reg_w = 1'b1;
      S_BRANCH: begin
        bus.ALUSrcB   = SRCB_IMM;
        bus.ResultSrc = RES_ALURESULT;
        pc_w          = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset so nothing writes while reset is held.
  assign bus.PCWrite  = pc_w  & reset;
  assign bus.IRWrite  = ir_w  & reset;
  assign bus.MemWrite = mem_w & reset;
  assign bus.RegWrite = reg_w & reset;

  assign bus.ImmSrc = op;
  assign bus.RegSrc = {op == OP_MEM, op == OP_BR};
  assign bus.state  = state;
  assign bus.flags  = flags;
endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed program steps plus random instructions,
// checked against per-instruction cycle/strobe/flag expectations.
module tb_mc_controller;
  import arm_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  logic [3:0] m_flags;
  logic [3:0] exp_q[$];
  logic [3:0] obs_q[$];

  mc_controller_if bus ();

  mc_controller dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic m_condex(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cf;
      4'd3:  return !cf;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cf && !z;
      4'd9:  return !cf || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // driver + reference: runs one instruction from FETCH back to FETCH
  task automatic run_instr(input logic [19:0] ins, input logic [3:0] af,
                           input int fw, input int mw);
    logic [3:0] cond, cmd;
    logic [1:0] op;
    logic [5:0] funct;
    logic       ex, is_dp, is_mem, is_br, ld, cmp;
    int e_cyc, e_rw, e_mw, e_pcw, e_adr;
    logic [2:0] e_alu, o_alu;
    int cyc, rw, mwc, pcw, irw, adr, fwc, mwk;
    logic left, done;
    logic [3:0] st;

    cond  = ins[19:16];
    op    = ins[15:14];
    funct = ins[13:8];
    cmd   = funct[4:1];
    ex     = m_condex(cond, m_flags);
    is_dp  = ex && op == 2'b00;
    is_mem = ex && op == 2'b01;
    is_br  = ex && op == 2'b10;
    ld     = funct[0];
    cmp    = cmd == 4'b1010;

    e_cyc = 2 + fw; e_rw = 0; e_mw = 0; e_pcw = 1; e_adr = 0; e_alu = 3'b111;
    if (is_mem) begin
      e_cyc = (ld ? 5 : 4) + fw + mw;
      e_rw  = ld ? 1 : 0;
      e_mw  = ld ? 0 : 1 + mw;
      e_adr = 1 + mw;
    end else if (is_br) begin
      e_cyc = 3 + fw;
      e_pcw = 2;
    end else if (is_dp) begin
      e_cyc = (cmp ? 3 : 4) + fw;
      e_rw  = cmp ? 0 : 1;
      case (cmd)
        4'b0010, 4'b1010: e_alu = 3'b001;
        4'b0000:          e_alu = 3'b010;
        4'b1100:          e_alu = 3'b011;
        default:          e_alu = 3'b000;
      endcase
    end

    bus.Instr    = ins;
    bus.ALUFlags = af;
    cyc = 0; rw = 0; mwc = 0; pcw = 0; irw = 0; adr = 0;
    fwc = fw; mwk = mw; left = 1'b0; done = 1'b0; o_alu = 3'b111;
    obs_q.delete();
    while (!done && cyc < 40) begin
      @(negedge clk);
      st = bus.state;
      if (st == S_FETCH) begin
        bus.MemReady = (fwc == 0);
        if (fwc > 0) fwc--;
      end else if (st == S_MEMRD || st == S_MEMWR) begin
        bus.MemReady = (mwk == 0);
        if (mwk > 0) mwk--;
      end else begin
        bus.MemReady = 1'($urandom_range(0, 1));
      end
      #1;
      cyc++;
      obs_q.push_back(st);
      if (bus.RegWrite) rw++;
      if (bus.MemWrite) mwc++;
      if (bus.PCWrite)  pcw++;
      if (bus.IRWrite)  irw++;
      if (bus.AdrSrc)   adr++;
      if (st == S_EXECR || st == S_EXECI) o_alu = bus.ALUControl;
      @(posedge clk);
      #1;
      if (bus.state != S_FETCH) left = 1'b1;
      else if (left) done = 1'b1;
    end
    check("timeout", done, 1'b1);

    if (is_dp && funct[0]) begin
      m_flags[3:2] = af[3:2];
      if (cmd == 4'b0100 || cmd == 4'b0010 || cmd == 4'b1010) m_flags[1:0] = af[1:0];
    end

    check("cycles", cyc, e_cyc);
    check("regwrite_count", rw, e_rw);
    check("memwrite_count", mwc, e_mw);
    check("pcwrite_count", pcw, e_pcw);
    check("irwrite_count", irw, 1);
    check("adrsrc_count", adr, e_adr);
    check("alucontrol", o_alu, e_alu);
    check("flags", bus.flags, m_flags);
    check("immsrc", bus.ImmSrc, op);
    check("regsrc", bus.RegSrc, {op == 2'b01, op == 2'b10});
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    m_flags    = 4'b0000;
    rst_n        = 1'b0;
    bus.Instr    = 20'hE0821;
    bus.ALUFlags = 4'b0000;
    bus.MemReady = 1'b1;

    // reset state: strobes low even with MemReady high
    #2;
    check("rst_state", bus.state, S_FETCH);
    check("rst_flags", bus.flags, 4'b0000);
    check("rst_pcwrite", bus.PCWrite, 1'b0);
    check("rst_irwrite", bus.IRWrite, 1'b0);
    check("rst_memwrite", bus.MemWrite, 1'b0);
    check("rst_regwrite", bus.RegWrite, 1'b0);
    bus.MemReady = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_state", bus.state, S_FETCH);

    // ADD R1,R2,R3 with explicit state trace
    run_instr(20'hE0821, 4'($urandom), 0, 0);
    exp_q = '{S_FETCH, S_DECODE, S_EXECR, S_ALUWB};
    check("add_trace_len", obs_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_q.size() > 0)
      check("add_trace", obs_q.pop_front(), exp_q.pop_front());

    // SUBS R1,R2,#5 sets Z; BEQ taken
    run_instr(20'hE2521, 4'b0100, 0, 0);
    check("subs_flags", bus.flags, 4'b0100);
    run_instr(20'h0A000, 4'($urandom), 1, 0);

    // LDR with 3 wait cycles, STR with 2
    run_instr(20'hE5921, 4'($urandom), 0, 3);
    run_instr(20'hE5821, 4'($urandom), 0, 2);

    // CMP leaves Z set; BNE then fails
    run_instr(20'hE1510, 4'b0100, 0, 0);
    run_instr(20'h1A000, 4'($urandom), 0, 0);

    // randomized instruction stream
    for (int i = 0; i < 40; i++) begin
      logic [19:0] ins;
      ins = 20'($urandom);
      if ($urandom_range(0, 1) == 1) ins[19:16] = 4'hE;
      run_instr(ins, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // reset in the middle of a stalled store
    bus.Instr    = 20'hE5821;
    bus.MemReady = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.MemReady = 1'b0;
    #1;
    check("memwr_state", bus.state, S_MEMWR);
    check("memwr_strobe", bus.MemWrite, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_memwrite", bus.MemWrite, 1'b0);
    check("rst_mid_state", bus.state, S_FETCH);
    check("rst_mid_flags", bus.flags, 4'b0000);
    bus.MemReady = 1'b1;
    #1;
    check("rst_mid_pcwrite", bus.PCWrite, 1'b0);
    check("rst_mid_irwrite", bus.IRWrite, 1'b0);
    bus.MemReady = 1'b0;
    m_flags = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("restart_state", bus.state, S_FETCH);
    run_instr(20'hE0821, 4'($urandom), 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
